// File: rtl/ay_bus_pkg.sv
// Shared types for the AY-3-8910 bus controller: PSG bus commands, FSM states
// and the port-strobe decode helpers.
package ay_bus_pkg;

  // Encoding is the PSG pin pair {BDIR, BC1}.
  typedef enum logic [1:0] {
    CMD_INACT = 2'b00,
    CMD_RDPSG = 2'b01,
    CMD_WRPSG = 2'b10,
    CMD_LADDR = 2'b11
  } ay_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } ay_state_t;

  typedef struct packed {
    ay_cmd_t    cmd;
    logic [7:0] data;
  } ay_req_t;

  function automatic ay_cmd_t decode_cmd(input logic dout, input logic iwrbt);
    if (!dout) return CMD_RDPSG;
    return iwrbt ? CMD_LADDR : CMD_WRPSG;
  endfunction

  // The top N_CHIPS address values are chip selects and never reach the bus.
  function automatic logic is_select(input ay_req_t req, input int n_chips);
    return (req.cmd == CMD_LADDR) && (int'(req.data) >= 256 - n_chips);
  endfunction

endpackage

// File: rtl/ay_port_sync.sv
// Resynchronises the BK parallel-port handshake and data into clk and flags
// the synchronised strobe rising edge. Data travels with strobe stage by stage.
module ay_port_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe_i,
  input  logic       dout_i,
  input  logic       iwrbt_i,
  input  logic [7:0] port_do_i,
  output logic       strobe_o,
  output logic       strobe_rise_o,
  output logic       dout_o,
  output logic       iwrbt_o,
  output logic [7:0] data_o
);

  logic [SYNC_STAGES-1:0] strobe_q;
  logic [SYNC_STAGES-1:0] dout_q;
  logic [SYNC_STAGES-1:0] iwrbt_q;
  logic [7:0]             data_q [SYNC_STAGES];
  logic                   strobe_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q      <= '0;
      dout_q        <= '0;
      iwrbt_q       <= '0;
      strobe_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_q[i] <= '0;
    end else begin
      strobe_q      <= {strobe_q[SYNC_STAGES-2:0], strobe_i};
      dout_q        <= {dout_q[SYNC_STAGES-2:0], dout_i};
      iwrbt_q       <= {iwrbt_q[SYNC_STAGES-2:0], iwrbt_i};
      strobe_prev_q <= strobe_q[SYNC_STAGES-1];
      data_q[0]     <= port_do_i;
      for (int i = 1; i < SYNC_STAGES; i++) data_q[i] <= data_q[i-1];
    end
  end

  // prev is cleared with the chain, so reset release cannot fake an edge.
  assign strobe_o      = strobe_q[SYNC_STAGES-1];
  assign strobe_rise_o = strobe_q[SYNC_STAGES-1] & ~strobe_prev_q;
  assign dout_o        = dout_q[SYNC_STAGES-1];
  assign iwrbt_o       = iwrbt_q[SYNC_STAGES-1];
  assign data_o        = data_q[SYNC_STAGES-1];

endmodule

// File: rtl/ay_bus_ctrl.sv
// BK-0011M parallel port to AY-3-8910 bus controller: decodes port strobes into
// PSG bus commands and drives timed BDIR/BC1 pulses to the selected chip.
module ay_bus_ctrl
  import ay_bus_pkg::*;
#(
  parameter int N_CHIPS     = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       strobe,
  input  logic                                       dout,
  input  logic                                       iwrbt,
  input  logic [7:0]                                 port_do,
  output logic [7:0]                                 port_di,
  output logic                                       port_di_valid,
  output logic [N_CHIPS-1:0]                         ay_bdir,
  output logic [N_CHIPS-1:0]                         ay_bc1,
  output logic [7:0]                                 ay_da_o,
  output logic                                       ay_da_oe,
  input  logic [7:0]                                 ay_da_i,
  output logic [((N_CHIPS > 1) ? $clog2(N_CHIPS) : 1)-1:0] chip_sel,
  output logic                                       busy,
  output logic                                       overrun,
  output ay_state_t                                  dbg_state
);

  localparam int CS_W    = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  logic       s_strobe, s_rise, s_dout, s_iwrbt;
  logic [7:0] s_data;

  ay_port_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .rst          (reset),
    .strobe_i     (strobe),
    .dout_i       (dout),
    .iwrbt_i      (iwrbt),
    .port_do_i    (port_do),
    .strobe_o     (s_strobe),
    .strobe_rise_o(s_rise),
    .dout_o       (s_dout),
    .iwrbt_o      (s_iwrbt),
    .data_o       (s_data)
  );

  ay_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  ay_req_t             arr_q, cur_q, cur_d, buf_q, buf_d, pend;
  logic                arr_v_q, buf_v_q, buf_v_d, pend_v, take;
  logic [CS_W-1:0]     chip_sel_q, chip_sel_d;
  logic [7:0]          sel_idx;
  logic                overrun_q, overrun_d;
  logic [N_CHIPS-1:0]  bdir_q, bdir_d, bc1_q, bc1_d;
  logic [7:0]          da_o_q, da_o_d, port_di_q, port_di_d;
  logic                da_oe_q, da_oe_d, di_valid_q, di_valid_d, busy_q, busy_d;
  logic                hold_entry, hold_exit;

  // State, counter, buffer, command register and all output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      arr_v_q    <= 1'b0;
      arr_q      <= '0;
      cur_q      <= '0;
      buf_v_q    <= 1'b0;
      buf_q      <= '0;
      chip_sel_q <= '0;
      overrun_q  <= 1'b0;
      bdir_q     <= '0;
      bc1_q      <= '0;
      da_o_q     <= '0;
      da_oe_q    <= 1'b0;
      port_di_q  <= '0;
      di_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arr_v_q    <= s_rise;
      if (s_rise) begin
        arr_q.cmd  <= decode_cmd(s_dout, s_iwrbt);
        arr_q.data <= s_data;
      end
      cur_q      <= cur_d;
      buf_v_q    <= buf_v_d;
      buf_q      <= buf_d;
      chip_sel_q <= chip_sel_d;
      overrun_q  <= overrun_d;
      bdir_q     <= bdir_d;
      bc1_q      <= bc1_d;
      da_o_q     <= da_o_d;
      da_oe_q    <= da_oe_d;
      port_di_q  <= port_di_d;
      di_valid_q <= di_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Next state. "take" marks the cycles where a new command may start: any
  // IDLE cycle and the last GAP cycle. The buffer always has priority over a
  // fresh arrival so commands keep their order.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    buf_d      = buf_q;
    buf_v_d    = buf_v_q;
    chip_sel_d = chip_sel_q;
    overrun_d  = overrun_q;
    take       = 1'b0;
    pend       = buf_v_q ? buf_q : arr_q;
    pend_v     = buf_v_q | arr_v_q;
    sel_idx    = ~pend.data;

    case (state_q)
      IDLE: take = 1'b1;
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (MODE == 0 || !s_strobe) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          take    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take && pend_v) begin
      if (is_select(pend, N_CHIPS)) begin
        chip_sel_d = sel_idx[CS_W-1:0];
      end else begin
        state_d = HOLD;
        cur_d   = pend;
        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      end
    end

    if (take && buf_v_q) begin
      buf_v_d = arr_v_q;
      buf_d   = arr_q;
    end else if (!take && arr_v_q) begin
      if (!buf_v_q) begin
        buf_v_d = 1'b1;
        buf_d   = arr_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign hold_entry = (state_d == HOLD) && (state_q != HOLD);
  assign hold_exit  = (state_q == HOLD) && (state_d == GAP);

  // Outputs are computed from next-state values and registered, so pins
  // switch on the same edge as the FSM. Write data stays driven one GAP cycle.
  always_comb begin
    bdir_d     = '0;
    bc1_d      = '0;
    da_o_d     = da_o_q;
    port_di_d  = port_di_q;
    di_valid_d = di_valid_q;
    if (state_d == HOLD) begin
      bdir_d[chip_sel_d] = cur_d.cmd[1];
      bc1_d[chip_sel_d]  = cur_d.cmd[0];
    end
    if (hold_entry) begin
      di_valid_d = 1'b0;
      if (cur_d.cmd[1]) da_o_d = cur_d.data;
    end
    da_oe_d = ((state_d == HOLD) && cur_d.cmd[1]) || (hold_exit && cur_q.cmd[1]);
    if (hold_exit && (cur_q.cmd == CMD_RDPSG)) begin
      port_di_d  = ay_da_i;
      di_valid_d = 1'b1;
    end
    busy_d = (state_d != IDLE) || buf_v_d;
  end

  assign port_di       = port_di_q;
  assign port_di_valid = di_valid_q;
  assign ay_bdir       = bdir_q;
  assign ay_bc1        = bc1_q;
  assign ay_da_o       = da_o_q;
  assign ay_da_oe      = da_oe_q;
  assign chip_sel      = chip_sel_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ay_bus_ctrl.sv
// Directed bench for ay_bus_ctrl: a pulse monitor checks every bus pulse
// against an expected queue; timing-specific points are checked inline.
module tb_ay_bus_ctrl;
  import ay_bus_pkg::*;

  localparam int W = 27;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe = 1'b0, strobe1 = 1'b0, dout = 1'b0, iwrbt = 1'b1;
  logic [7:0] port_do = 8'h00, ay_da_i = 8'h00;

  logic [7:0] port_di, ay_da_o;
  logic       port_di_valid, ay_da_oe, busy, overrun;
  logic [1:0] ay_bdir, ay_bc1;
  logic [0:0] chip_sel;
  ay_state_t  dbg_state;

  logic [7:0] port_di1, ay_da_o1;
  logic       port_di_valid1, ay_da_oe1, busy1, overrun1;
  logic [1:0] ay_bdir1, ay_bc11;
  logic [0:0] chip_sel1;
  ay_state_t  dbg_state1;

  ay_bus_ctrl #(.N_CHIPS(2), .HOLD_CYCLES(4), .GAP_CYCLES(2), .SYNC_STAGES(2), .MODE(0)) dut (
    .clk(clk), .reset(rst), .strobe(strobe), .dout(dout), .iwrbt(iwrbt), .port_do(port_do),
    .port_di(port_di), .port_di_valid(port_di_valid), .ay_bdir(ay_bdir), .ay_bc1(ay_bc1),
    .ay_da_o(ay_da_o), .ay_da_oe(ay_da_oe), .ay_da_i(ay_da_i), .chip_sel(chip_sel),
    .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  ay_bus_ctrl #(.N_CHIPS(2), .HOLD_CYCLES(4), .GAP_CYCLES(2), .SYNC_STAGES(2), .MODE(1)) dut1 (
    .clk(clk), .reset(rst), .strobe(strobe1), .dout(dout), .iwrbt(iwrbt), .port_do(port_do),
    .port_di(port_di1), .port_di_valid(port_di_valid1), .ay_bdir(ay_bdir1), .ay_bc1(ay_bc11),
    .ay_da_o(ay_da_o1), .ay_da_oe(ay_da_oe1), .ay_da_i(ay_da_i), .chip_sel(chip_sel1),
    .busy(busy1), .overrun(overrun1), .dbg_state(dbg_state1)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_vec = 0, n_fail = 0, n_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse record: {bdir, bc1, data (0 when not driven), oe, oe in first idle
  // cycle, pulse stable, length, idle cycles before it (saturating at 15)}.
  function automatic logic [W-1:0] mk(input logic [1:0] bdir, input logic [1:0] bc1,
                                      input logic [7:0] da, input logic oe, input logic oe_gap,
                                      input logic [7:0] len, input logic [3:0] gap);
    return {bdir, bc1, da, oe, oe_gap, 1'b1, len, gap};
  endfunction

  logic         in_p = 1'b0, p_oe = 1'b0, p_ok = 1'b0;
  logic [1:0]   p_bdir = '0, p_bc1 = '0;
  logic [7:0]   p_da = '0, p_len = '0;
  logic [3:0]   p_gap = '0, gap_c = 4'd15;
  logic [W-1:0] obs_r, exp_r;

  always @(negedge clk) begin
    if (rst) begin
      in_p  = 1'b0;
      gap_c = 4'd15;
    end else if (|{ay_bdir, ay_bc1}) begin
      if (!in_p) begin
        in_p   = 1'b1;
        p_bdir = ay_bdir;
        p_bc1  = ay_bc1;
        p_oe   = ay_da_oe;
        p_da   = ay_da_oe ? ay_da_o : 8'h00;
        p_len  = 8'd1;
        p_ok   = 1'b1;
        p_gap  = gap_c;
      end else begin
        p_len++;
        if (ay_bdir !== p_bdir || ay_bc1 !== p_bc1 || ay_da_oe !== p_oe ||
            (p_oe && ay_da_o !== p_da)) p_ok = 1'b0;
      end
      gap_c = 4'd0;
    end else begin
      if (in_p) begin
        in_p = 1'b0;
        n_pulses++;
        obs_r = {p_bdir, p_bc1, p_da, p_oe, ay_da_oe, p_ok, p_len, p_gap};
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("pulse", 32'(obs_r), 32'(exp_r));
      end
      if (gap_c != 4'd15) gap_c++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe_pulse(input logic d, input logic w, input logic [7:0] data, input int len);
    dout    = d;
    iwrbt   = w;
    port_do = data;
    strobe  = 1'b1;
    repeat (len) @(negedge clk);
    strobe = 1'b0;
  endtask

  // MODE=1 instance: strobe high for L cycles, count the pulse length.
  task automatic mode1_run(input int len, input int exp_len);
    int          cnt = 0;
    logic [1:0]  code = 2'b00;
    dout    = 1'b1;
    iwrbt   = 1'b1;
    port_do = 8'h0A;
    strobe1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i + 1 == len) strobe1 = 1'b0;
      if (|{ay_bdir1, ay_bc11}) begin
        cnt++;
        code = {ay_bdir1[0], ay_bc11[0]};
      end
    end
    check("m1_len", cnt, exp_len);
    check("m1_code", 32'(code), 32'h3);
  endtask

  int saved;

  initial begin
    cyc(2);
    check("rst_bdir", 32'(ay_bdir), 0);
    check("rst_bc1", 32'(ay_bc1), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    cyc(3);
    check("rel_state", 32'(dbg_state), 32'(IDLE));
    check("rel_oe", 32'(ay_da_oe), 0);
    check("rel_overrun", 32'(overrun), 0);

    // Word write then byte write to chip 0; second is buffered behind the first.
    exp_q.push_back(mk(2'b01, 2'b01, 8'h07, 1'b1, 1'b1, 8'd4, 4'd15));
    exp_q.push_back(mk(2'b01, 2'b00, 8'h38, 1'b1, 1'b1, 8'd4, 4'd2));
    strobe_pulse(1'b1, 1'b1, 8'h07, 2);
    cyc(1);
    strobe_pulse(1'b1, 1'b0, 8'h38, 2);
    cyc(1);
    check("t1_busy", 32'(busy), 1);
    check("t1_oe", 32'(ay_da_oe), 1);
    check("t1_da", 32'(ay_da_o), 32'h07);
    cyc(30);

    // Select chip 1 (no bus cycle), then LADDR lands on chip 1 only.
    strobe_pulse(1'b1, 1'b1, 8'hFE, 1);
    cyc(2);
    check("sel_before", 32'(chip_sel), 0);
    cyc(1);
    check("sel_after", 32'(chip_sel), 1);
    check("sel_idle", 32'(busy), 0);
    cyc(20);
    exp_q.push_back(mk(2'b10, 2'b10, 8'h08, 1'b1, 1'b1, 8'd4, 4'd15));
    strobe_pulse(1'b1, 1'b1, 8'h08, 1);
    cyc(25);

    // Read from chip 0.
    strobe_pulse(1'b1, 1'b1, 8'hFF, 1);
    cyc(10);
    check("sel0", 32'(chip_sel), 0);
    ay_da_i = 8'h5A;
    exp_q.push_back(mk(2'b00, 2'b01, 8'h00, 1'b0, 1'b0, 8'd4, 4'd15));
    strobe_pulse(1'b0, 1'b1, 8'h00, 1);
    cyc(4);
    check("rd_oe", 32'(ay_da_oe), 0);
    check("rd_bc1", 32'(ay_bc1), 32'h1);
    cyc(2);
    check("rd_valid_hold", 32'(port_di_valid), 0);
    cyc(1);
    check("rd_di", 32'(port_di), 32'h5A);
    check("rd_valid", 32'(port_di_valid), 1);
    check("rd_oe_gap", 32'(ay_da_oe), 0);
    ay_da_i = 8'hA5;
    cyc(20);
    check("rd_di_held", 32'(port_di), 32'h5A);

    // A select keeps port_di_valid; the next bus command clears it on HOLD entry.
    strobe_pulse(1'b1, 1'b1, 8'hFE, 1);
    cyc(10);
    check("valid_after_sel", 32'(port_di_valid), 1);
    exp_q.push_back(mk(2'b10, 2'b10, 8'h0C, 1'b1, 1'b1, 8'd4, 4'd15));
    strobe_pulse(1'b1, 1'b1, 8'h0C, 1);
    cyc(2);
    check("valid_pre_hold", 32'(port_di_valid), 1);
    cyc(1);
    check("valid_cleared", 32'(port_di_valid), 0);
    cyc(20);
    strobe_pulse(1'b1, 1'b1, 8'hFF, 1);
    cyc(20);

    // Third command arrives exactly as the buffer drains: accepted.
    exp_q.push_back(mk(2'b01, 2'b01, 8'h01, 1'b1, 1'b1, 8'd4, 4'd15));
    exp_q.push_back(mk(2'b01, 2'b00, 8'h02, 1'b1, 1'b1, 8'd4, 4'd2));
    exp_q.push_back(mk(2'b01, 2'b00, 8'h03, 1'b1, 1'b1, 8'd4, 4'd2));
    strobe_pulse(1'b1, 1'b1, 8'h01, 1);
    cyc(1);
    strobe_pulse(1'b1, 1'b0, 8'h02, 1);
    cyc(3);
    strobe_pulse(1'b1, 1'b0, 8'h03, 1);
    cyc(30);
    check("accept_no_overrun", 32'(overrun), 0);

    // Three strobes two cycles apart: third finds the buffer full and is dropped.
    exp_q.push_back(mk(2'b01, 2'b01, 8'h04, 1'b1, 1'b1, 8'd4, 4'd15));
    exp_q.push_back(mk(2'b01, 2'b00, 8'h05, 1'b1, 1'b1, 8'd4, 4'd2));
    strobe_pulse(1'b1, 1'b1, 8'h04, 1);
    cyc(1);
    strobe_pulse(1'b1, 1'b0, 8'h05, 1);
    cyc(1);
    strobe_pulse(1'b1, 1'b0, 8'h06, 1);
    check("ovr_busy", 32'(busy), 1);
    cyc(30);
    check("ovr_sticky", 32'(overrun), 1);
    check("ovr_idle", 32'(busy), 0);

    // MODE=1: pulse ends one cycle after the synchronised strobe is seen low,
    // never shorter than 4 cycles.
    mode1_run(10, 9);
    cyc(10);
    mode1_run(1, 4);
    cyc(10);

    // Reset in the second HOLD cycle of a chip-1 word write.
    strobe_pulse(1'b1, 1'b1, 8'hFE, 1);
    cyc(10);
    saved = n_pulses;
    strobe_pulse(1'b1, 1'b1, 8'h0D, 1);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_bdir", 32'(ay_bdir), 32'h2);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_bdir", 32'(ay_bdir), 0);
    check("rst_mid_bc1", 32'(ay_bc1), 0);
    check("rst_mid_oe", 32'(ay_da_oe), 0);
    check("rst_mid_da", 32'(ay_da_o), 0);
    check("rst_mid_di", 32'(port_di), 0);
    check("rst_mid_valid", 32'(port_di_valid), 0);
    check("rst_mid_sel", 32'(chip_sel), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_ovr", 32'(overrun), 0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    cyc(3);
    rst = 1'b0;
    cyc(25);
    check("no_pulse_after_rst", n_pulses, saved);
    check("post_rst_busy", 32'(busy), 0);
    exp_q.push_back(mk(2'b01, 2'b01, 8'h0E, 1'b1, 1'b1, 8'd4, 4'd15));
    strobe_pulse(1'b1, 1'b1, 8'h0E, 1);
    cyc(25);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
